// File: rtl/alu_result_stage.sv
// Sequencer for an external 4-bit adder/subtractor: registers operands, waits SETTLE_CYCLES, captures the result into a 2-entry FIFO.
// Define ALU_FLAGS_EN to compute and store the zero/overflow flags; otherwise out_zero/out_ovf read 0.
module alu_result_stage #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [1:0] in_s,
    input  logic       in_cin,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_s,
    output logic       alu_cin,
    input  logic [3:0] alu_d,
    input  logic       alu_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_d,
    output logic       out_cout,
    output logic       out_zero,
    output logic       out_ovf,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

`ifdef ALU_FLAGS_EN
    localparam int EW = 7;
`else
    localparam int EW = 5;
`endif

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          accept, push, pop;
    logic [1:0]    count;
    logic          wr_ptr, rd_ptr;
    logic [EW-1:0] mem [2];
    logic [EW-1:0] entry;

    // Handshake: a transfer occurs on a rising edge where valid and ready are
    // both high; valid never waits on ready, and ready depends only on state.
    assign in_ready  = (state == IDLE) && (count < 2'd2);
    assign accept    = in_valid && in_ready;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = (state == CAPTURE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = 4'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) state_nxt = CAPTURE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands only change on accept, so the datapath sees stable inputs for the whole settle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= 4'd0;
            alu_b   <= 4'd0;
            alu_s   <= 2'd0;
            alu_cin <= 1'b0;
        end else if (accept) begin
            alu_a   <= in_a;
            alu_b   <= in_b;
            alu_s   <= in_s;
            alu_cin <= in_cin;
        end
    end

`ifdef ALU_FLAGS_EN
    logic y_msb, zero, ovf;

    // Only the sign bit of the effective B operand matters for overflow.
    always_comb begin
        case (alu_s)
            2'b00:   y_msb = alu_b[3];
            2'b01:   y_msb = ~alu_b[3];
            2'b10:   y_msb = 1'b0;
            default: y_msb = 1'b1;
        endcase
        zero  = (alu_d == 4'd0);
        ovf   = (alu_a[3] == y_msb) && (alu_d[3] != alu_a[3]);
        entry = {alu_d, alu_cout, zero, ovf};
    end

    assign {out_d, out_cout, out_zero, out_ovf} = mem[rd_ptr];
`else
    assign entry             = {alu_d, alu_cout};
    assign {out_d, out_cout} = mem[rd_ptr];
    assign out_zero          = 1'b0;
    assign out_ovf           = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed steps plus random ops, checked against an arithmetic reference model.
// Honours ALU_FLAGS_EN the same way as the design (flags expected 0 when undefined).
module tb_alu_result_stage;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, in_cin, alu_cin, alu_cout;
  logic [3:0] in_a, in_b, alu_a, alu_b, alu_d, out_d;
  logic [1:0] in_s, alu_s, dbg_state;
  logic       out_valid, out_ready, out_cout, out_zero, out_ovf;

  int n_vec = 0;
  int n_err = 0;
  int n_pops = 0;
  int accept_pops = 0;
  int dp_age = 0;
  logic [10:0] dp_prev = '0;
  logic        hold = 1'b0;
  logic [6:0]  held = '0;
  logic        done = 1'b0;
  logic [6:0]  exp_q[$];

  alu_result_stage #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_cin(in_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_d(alu_d), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
    .out_cout(out_cout), .out_zero(out_zero), .out_ovf(out_ovf),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: {d, cout, zero, ovf} from plain integer arithmetic.
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] s, input logic cin);
    int ai, y, sum, sa, sy, ss;
    logic zero, ovf;
    ai = int'(a);
    case (s)
      2'd0:    y = int'(b);
      2'd1:    y = 15 - int'(b);
      2'd2:    y = 0;
      default: y = 15;
    endcase
    sum  = ai + y + int'(cin);
    sa   = (ai >= 8) ? ai - 16 : ai;
    sy   = (y >= 8) ? y - 16 : y;
    ss   = sa + sy + int'(cin);
    ovf  = (ss > 7) || (ss < -8);
    zero = (sum % 16) == 0;
`ifndef ALU_FLAGS_EN
    zero = 1'b0;
    ovf  = 1'b0;
`endif
    return {4'(sum % 16), 1'(sum / 16), zero, ovf};
  endfunction

  // Datapath model: output is garbage until operands have been stable for SETTLE edges.
  always @(negedge clk) begin
    if ({alu_a, alu_b, alu_s, alu_cin} !== dp_prev) begin
      dp_prev = {alu_a, alu_b, alu_s, alu_cin};
      dp_age  = 0;
    end else if (dp_age < 100) begin
      dp_age++;
    end
  end

  logic [4:0] dp_true;
  assign dp_true = model(alu_a, alu_b, alu_s, alu_cin) >> 2;
  assign {alu_d, alu_cout} = (dp_age >= SETTLE) ? dp_true : (dp_true ^ 5'h1A);

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and stability monitor.
  always @(negedge clk) begin
    if (rst_n && hold)
      check("hold_stable", {out_valid, out_d, out_cout, out_zero, out_ovf}, {1'b1, held});
    if (rst_n && out_valid && out_ready) begin
      check("out_expected", 8'(exp_q.size() != 0), 8'd1);
      if (exp_q.size() != 0)
        check("result", {1'b0, out_d, out_cout, out_zero, out_ovf}, {1'b0, exp_q.pop_front()});
      n_pops++;
    end
    hold = rst_n && out_valid && !out_ready;
    held = {out_d, out_cout, out_zero, out_ovf};
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] s, input logic cin);
    int budget = 0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_s = s; in_cin = cin; in_valid = 1'b1;
    while (!in_ready && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) begin
      check("accept_timeout", 8'(budget), 8'd0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(model(a, b, s, cin));
    accept_pops = n_pops;
    #1;
    in_valid = 1'b0;
    in_a = 4'($urandom); in_b = 4'($urandom); in_s = 2'($urandom); in_cin = 1'($urandom);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] d, input logic cout,
                            input logic zero, input logic ovf);
    int budget = 0;
    logic fz, fo;
`ifdef ALU_FLAGS_EN
    fz = zero; fo = ovf;
`else
    fz = 1'b0; fo = 1'b0;
`endif
    @(negedge clk);
    while (!out_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_valid"}, 8'(out_valid), 8'd1);
    check(tag, {1'b0, out_d, out_cout, out_zero, out_ovf}, {1'b0, d, cout, fz, fo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0; in_cin = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out", {out_valid, out_d, out_cout, out_zero, out_ovf}, 8'd0);
    check("rst_alu", {alu_a, alu_b}, 8'd0);
    check("rst_alu_s", {5'd0, alu_s, alu_cin}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 8'(in_ready), 8'd1);

    // 3+3: latency, operand hold and in_ready during the settle window
    send(4'd3, 4'd3, 2'd0, 1'b0);
    for (int k = 1; k <= SETTLE + 1; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("lat_valid_%0d", k), 8'(out_valid), 8'(k == SETTLE + 1));
      check($sformatf("lat_ready_%0d", k), 8'(in_ready), 8'(k == SETTLE + 1));
      if (k == 2) check("alu_held", {alu_a, alu_b}, 8'h33);
    end
    check("r3p3", {1'b0, out_d, out_cout, out_zero, out_ovf}, {1'b0, 4'd6, 3'b000});

    send(4'd5, 4'd5, 2'd1, 1'b1);
    expect_out("r5m5", 4'd0, 1'b1, 1'b1, 1'b0);
    send(4'd7, 4'd1, 2'd0, 1'b0);
    expect_out("r7p1", 4'd8, 1'b0, 1'b0, 1'b1);
    send(4'd0, 4'($urandom), 2'd3, 1'b0);
    expect_out("r0m1", 4'd15, 1'b0, 1'b0, 1'b0);

    // Backpressure: two results buffered, third held off until the first pop
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        send(4'd1, 4'd1, 2'd0, 1'b0);
        send(4'd2, 4'd2, 2'd0, 1'b0);
        send(4'd3, 4'd3, 2'd0, 1'b0);
      end
      begin
        repeat (25) @(posedge clk);
        #1;
        check("bp_valid", 8'(out_valid), 8'd1);
        check("bp_in_ready", 8'(in_ready), 8'd0);
        check("bp_head", {4'd0, out_d}, 8'd2);
        out_ready = 1'b1;
      end
    join
    check("third_after_pop", 8'(accept_pops != 0), 8'd1);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("bp_drain", 8'(exp_q.size()), 8'd0);

    // Reset in the middle of settling discards the operation
    send(4'd1, 4'd1, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_out", {out_valid, alu_a, 3'd0}, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 8'(in_ready), 8'd1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("rst_mid_no_out", 8'(seen), 8'd0);
    send(4'd1, 4'd2, 2'd0, 1'b0);
    expect_out("r1p2", 4'd3, 1'b0, 1'b0, 1'b0);

    // Random operations with random output backpressure
    fork
      begin
        repeat (40) send(4'($urandom), 4'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        done = 1'b1;
      end
      begin
        for (int g = 0; g < 5000 && !done; g++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("rand_drain", 8'(exp_q.size()), 8'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, default 4, number of clock cycles operands are held stable before the result is sampled (legal 1..15).
REQ-002 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: in_valid  input  1  operation request.
REQ-005 SHALL have ports: in_ready  output  1  operation accepted when in_valid and in_ready both high at a rising edge.
REQ-006 SHALL have ports: in_a, in_b  input  4 each  operands.
REQ-007 SHALL have ports: in_s  input  2  operand-B select; in_cin  input  1  carry-in.
REQ-008 SHALL have ports: alu_a, alu_b  output  4 each; alu_s  output  2; alu_cin  output  1; all registered and driven to the 4-bit adder/subtractor datapath.
REQ-009 SHALL have ports: alu_d  input  4; alu_cout  input  1; result from that datapath.
REQ-010 SHALL have ports: out_valid  output  1; out_ready  input  1; out_d  output  4; out_cout  output  1; out_zero  output  1; out_ovf  output  1.

Function
REQ-011 SHALL implement FSM states IDLE, SETTLE, CAPTURE.
REQ-012 SHALL drive in_ready high only in IDLE with output FIFO count < 2.
REQ-013 IDLE: on accept, SHALL register in_a/in_b/in_s/in_cin into alu_*, load counter with SETTLE_CYCLES-1, go to SETTLE.
REQ-014 SETTLE: SHALL hold alu_* constant, decrement counter each cycle, go to CAPTURE in the cycle after counter reads 0.
REQ-015 CAPTURE: SHALL push {alu_d, alu_cout, zero, ovf} into output FIFO, return to IDLE in one cycle.
REQ-016 Accept edge to out_valid-high edge (FIFO empty) SHALL be exactly SETTLE_CYCLES+1 edges; alu_d SHALL never be sampled outside CAPTURE.
REQ-017 Output FIFO SHALL be 2 entries, in order; out_valid high while non-empty; pop when out_valid and out_ready both high at an edge; out_d/out_cout/out_zero/out_ovf show head entry.
REQ-018 Push and pop on same edge SHALL leave count unchanged; at most one operation in flight, so the FIFO never overflows.
REQ-019 zero SHALL be 1 iff alu_d == 0 (cout ignored).
REQ-020 ovf SHALL be signed overflow of a + y + cin, y = b (s=00), ~b (s=01), 4'b0000 (s=10), 4'b1111 (s=11): ovf = (a[3]==y[3]) and (alu_d[3]!=a[3]).
REQ-021 Operand changes on in_* while not accepted SHALL not affect alu_*.
REQ-022 out_* data SHALL hold stable while out_valid high and out_ready low.

Reset
REQ-023 rst_n low SHALL asynchronously force: FSM IDLE, counter 0, FIFO empty, alu_* 0, out_valid 0, out_d/out_cout/out_zero/out_ovf 0; in_ready reflects IDLE/empty (1) once rst_n high.
REQ-024 Reset during SETTLE/CAPTURE SHALL discard the operation; no result emitted after release.

Configuration
REQ-025 Macro ALU_FLAGS_EN: defined -> out_zero/out_ovf per REQ-019/020, stored in FIFO; undefined -> flag logic/storage omitted, out_zero and out_ovf tied 0, ports retained.

Verification (SETTLE_CYCLES=4, out_ready=1 unless stated)
REQ-026 a=3,b=3,s=00,cin=0 -> out_d=6,cout=0,zero=0,ovf=0, out_valid exactly 5 edges after accept.
REQ-027 a=5,b=5,s=01,cin=1 -> out_d=0,cout=1,zero=1,ovf=0.
REQ-028 a=7,b=1,s=00,cin=0 -> out_d=8,cout=0,ovf=1; a=0,s=11,cin=0 -> out_d=15,cout=0,ovf=0.
REQ-029 out_ready=0, offer 3 ops (1+1, 2+2, 3+3) -> two results buffered, in_ready low; raise out_ready -> 2,4,6 delivered in order, third accepted after first pop.
REQ-030 rst_n pulsed low in SETTLE -> out_valid stays 0, in_ready 1 after release, next op 1+2 -> out_d=3.
REQ-031 ALU_FLAGS_EN undefined, rerun REQ-027/028 -> out_zero=0, out_ovf=0, data identical.
